// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if: MEM-side inputs and GRF write-port outputs of the MEM/WB stage
interface wb_select_stage_if #(
   parameter int DW   = 32,
   parameter int NSRC = 4,
   parameter int SELW = 2,
   parameter int RAW  = 5,
   parameter int CNTW = 16
);
   logic              stall;
   logic              flush;
   logic              in_valid;
   logic              we_in;
   logic [RAW-1:0]    rt;
   logic [RAW-1:0]    rd;
   logic [1:0]        rd_sel;
   logic [NSRC*DW-1:0] src_data;
   logic [SELW-1:0]   src_sel;
   logic [1:0]        addr_lo;
   logic [2:0]        ld_type;
   logic              wb_valid;
   logic              wb_we;
   logic [RAW-1:0]    wb_addr;
   logic [DW-1:0]     wb_data;
   logic [CNTW-1:0]   wb_count;
   modport master (
      output stall, flush, in_valid, we_in, rt, rd, rd_sel, src_data, src_sel, addr_lo, ld_type,
      input  wb_valid, wb_we, wb_addr, wb_data, wb_count
   );
   modport slave (
      input  stall, flush, in_valid, we_in, rt, rd, rd_sel, src_data, src_sel, addr_lo, ld_type,
      output wb_valid, wb_we, wb_addr, wb_data, wb_count
   );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered MEM/WB boundary with dest/data select; WB_LOAD_EXT_EN adds load extraction on source 1
module wb_select_stage #(
   parameter int DW       = 32,
   parameter int NSRC     = 4,
   parameter int SELW     = 2,
   parameter int RAW      = 5,
   parameter int LINK_REG = 31,
   parameter int CNTW     = 16
) (
   input logic              clk,
   input logic              reset,
   wb_select_stage_if.slave bus
);
   logic [RAW-1:0]  w_addr;
   logic [DW-1:0]   w_sel;
   logic [DW-1:0]   w_data;
   logic            w_fault;
   logic            w_we;
   logic            r_valid;
   logic            r_we;
   logic [RAW-1:0]  r_addr;
   logic [DW-1:0]   r_data;
   logic [CNTW-1:0] r_count;
   // destination register: rt, rd, link register, or none
   always_comb begin
      w_addr = bus.rd_sel == 2'b00 ? bus.rt :
               bus.rd_sel == 2'b01 ? bus.rd :
               bus.rd_sel == 2'b10 ? RAW'(LINK_REG) : '0;
   end
   // N-way source select; indices past the last source yield zero
   always_comb begin
      w_sel = '0;
      for (int k = 0; k < NSRC; k++)
         if (int'(bus.src_sel) == k) w_sel = bus.src_data[k*DW +: DW];
   end
`ifdef WB_LOAD_EXT_EN
   logic [DW-1:0] w_raw1;
   logic [7:0]    w_b;
   logic [15:0]   w_h;
   logic          w_lw;
   logic          w_ld;
   // memory read data (source 1) shaped by load type; lw-like for unknown types
   always_comb begin
      w_raw1  = bus.src_data[DW +: DW];
      w_b     = w_raw1[{bus.addr_lo, 3'b000} +: 8];
      w_h     = w_raw1[{bus.addr_lo[1], 4'b0000} +: 16];
      w_lw    = bus.ld_type == 3'b000 || bus.ld_type > 3'b100;
      w_ld    = int'(bus.src_sel) == 1;
      w_fault = w_ld && (w_lw ? bus.addr_lo != 2'b00 :
                         (bus.ld_type == 3'b011 || bus.ld_type == 3'b100) ? bus.addr_lo[0] : 1'b0);
      w_data  = !w_ld ? w_sel :
                bus.ld_type == 3'b001 ? {{(DW-8){w_b[7]}}, w_b} :
                bus.ld_type == 3'b010 ? {{(DW-8){1'b0}}, w_b} :
                bus.ld_type == 3'b011 ? {{(DW-16){w_h[15]}}, w_h} :
                bus.ld_type == 3'b100 ? {{(DW-16){1'b0}}, w_h} : w_raw1;
   end
`else
   logic w_unused;
   assign w_unused = ^{bus.ld_type, bus.addr_lo};
   // raw pass-through: no extraction and no misalign suppression
   always_comb begin
      w_fault = 1'b0;
      w_data  = w_sel;
   end
`endif
   assign w_we = bus.in_valid & bus.we_in & (w_addr != '0) & ~w_fault;
   // stage register: reset, then flush bubble, then stall hold, else capture; count commits leaving unstalled
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         if (!bus.stall && r_valid && r_we) r_count <= r_count + CNTW'(1);
         if (bus.flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
         end else if (!bus.stall) begin
            r_valid <= bus.in_valid;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
         end
      end
   end
   assign bus.wb_valid = r_valid;
   assign bus.wb_we    = r_we;
   assign bus.wb_addr  = r_addr;
   assign bus.wb_data  = r_data;
   assign bus.wb_count = r_count;
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: directed plus random checks of two stage instances (4 and 3 sources) against a reference model
module tb_wb_select_stage;
`ifdef WB_LOAD_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, in_valid, we_in;
   logic [4:0]  rt, rd;
   logic [1:0]  rd_sel, addr_lo, src_sel;
   logic [2:0]  ld_type;
   logic [31:0] src [4];
   int          n_tests = 0;
   int          n_fail = 0;
   logic        e_valid [2];
   logic        e_we    [2];
   logic [4:0]  e_addr  [2];
   logic [31:0] e_data  [2];
   logic [15:0] e_cnt   [2];

   wb_select_stage_if #(.NSRC(4)) bus4 ();
   wb_select_stage_if #(.NSRC(3)) bus3 ();

   wb_select_stage #(.NSRC(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
   wb_select_stage #(.NSRC(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

   always #5 clk = ~clk;

   assign bus4.stall = stall;      assign bus3.stall = stall;
   assign bus4.flush = flush;      assign bus3.flush = flush;
   assign bus4.in_valid = in_valid; assign bus3.in_valid = in_valid;
   assign bus4.we_in = we_in;      assign bus3.we_in = we_in;
   assign bus4.rt = rt;            assign bus3.rt = rt;
   assign bus4.rd = rd;            assign bus3.rd = rd;
   assign bus4.rd_sel = rd_sel;    assign bus3.rd_sel = rd_sel;
   assign bus4.src_sel = src_sel;  assign bus3.src_sel = src_sel;
   assign bus4.addr_lo = addr_lo;  assign bus3.addr_lo = addr_lo;
   assign bus4.ld_type = ld_type;  assign bus3.ld_type = ld_type;
   assign bus4.src_data = {src[3], src[2], src[1], src[0]};
   assign bus3.src_data = {src[2], src[1], src[0]};

   function automatic logic [31:0] load_val(input logic [31:0] w, input int lt, input int lo);
      logic [31:0] b, h;
      b = (w >> (8 * lo)) & 32'hFF;
      h = (w >> (16 * (lo / 2))) & 32'hFFFF;
      case (lt)
         1: return b >= 128 ? b - 32'd256 : b;
         2: return b;
         3: return h >= 32768 ? h - 32'd65536 : h;
         4: return h;
         default: return w;
      endcase
   endfunction

   function automatic bit misaligned(input int lt, input int lo);
      if (lt == 3 || lt == 4) return lo % 2 != 0;
      if (lt == 1 || lt == 2) return 1'b0;
      return lo != 0;
   endfunction

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int ns = m == 0 ? 4 : 3;
         int dst, sel;
         logic [31:0] dat;
         bit flt;
         if (!reset) begin
            e_valid[m] = 0; e_we[m] = 0; e_addr[m] = 0; e_data[m] = 0; e_cnt[m] = 0;
         end else begin
            if (!stall && e_valid[m] && e_we[m]) e_cnt[m] = e_cnt[m] + 16'd1;
            if (flush) begin
               e_valid[m] = 0; e_we[m] = 0; e_addr[m] = 0; e_data[m] = 0;
            end else if (!stall) begin
               dst = rd_sel == 0 ? int'(rt) : rd_sel == 1 ? int'(rd) : rd_sel == 2 ? 31 : 0;
               sel = int'(src_sel);
               dat = sel < ns ? src[sel] : 32'd0;
               flt = 0;
               if (EXT && sel == 1) begin
                  dat = load_val(src[1], int'(ld_type), int'(addr_lo));
                  flt = misaligned(int'(ld_type), int'(addr_lo));
               end
               e_valid[m] = in_valid;
               e_we[m]    = in_valid && we_in && dst != 0 && !flt;
               e_addr[m]  = 5'(dst);
               e_data[m]  = dat;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " n4 valid"}, 32'(bus4.wb_valid), 32'(e_valid[0]));
      chk({tag, " n4 we"},    32'(bus4.wb_we),    32'(e_we[0]));
      chk({tag, " n4 addr"},  32'(bus4.wb_addr),  32'(e_addr[0]));
      chk({tag, " n4 data"},  bus4.wb_data,       e_data[0]);
      chk({tag, " n4 count"}, 32'(bus4.wb_count), 32'(e_cnt[0]));
      chk({tag, " n3 valid"}, 32'(bus3.wb_valid), 32'(e_valid[1]));
      chk({tag, " n3 we"},    32'(bus3.wb_we),    32'(e_we[1]));
      chk({tag, " n3 addr"},  32'(bus3.wb_addr),  32'(e_addr[1]));
      chk({tag, " n3 data"},  bus3.wb_data,       e_data[1]);
      chk({tag, " n3 count"}, 32'(bus3.wb_count), 32'(e_cnt[1]));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic load(input int lt, input int lo, input string tag);
      ld_type = 3'(lt);
      addr_lo = 2'(lo);
      step(tag);
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         e_valid[m] = 0; e_we[m] = 0; e_addr[m] = 0; e_data[m] = 0; e_cnt[m] = 0;
      end
      reset = 0; stall = 0; flush = 0; in_valid = 1; we_in = 1;
      rt = 0; rd = 5; rd_sel = 2'b01; src_sel = 2; addr_lo = 0; ld_type = 0;
      for (int i = 0; i < 4; i++) src[i] = $urandom;
      src[2] = 32'h1234_5678;
      step("reset1");
      step("reset2");
      chk("reset data zero", bus4.wb_data, 32'd0);
      reset = 1;
      step("capture");
      chk("capture data", bus4.wb_data, 32'h1234_5678);
      chk("capture addr", 32'(bus4.wb_addr), 32'd5);
      step("count");
      chk("count one", 32'(bus4.wb_count), 32'd1);
      rd_sel = 2'b10;
      step("link");
      chk("link addr", 32'(bus4.wb_addr), 32'd31);
      rd_sel = 2'b00; rt = 0;
      step("zero dest");
      chk("zero dest we", 32'(bus4.wb_we), 32'd0);
      step("zero dest hold count");
      rd_sel = 2'b01; rd = 7; src_sel = 0; src[0] = 32'hA5A5_0001;
      step("pre stall");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rd = 5'($urandom_range(1, 31));
         src[0] = $urandom;
         step("stall hold");
         chk("stall data held", bus4.wb_data, 32'hA5A5_0001);
      end
      flush = 1;
      step("stall+flush");
      chk("flush valid", 32'(bus4.wb_valid), 32'd0);
      stall = 0; flush = 0;
      step("after flush");
      src_sel = 3; src[3] = 32'hDEAD_BEEF;
      step("out of range");
      chk("oor n3 data", bus3.wb_data, 32'd0);
      src_sel = 1; src[1] = 32'h80FF_7F01; rd = 9;
      load(1, 2, "lb lo2");
      load(2, 3, "lbu lo3");
      load(3, 2, "lh lo2");
      load(4, 0, "lhu lo0");
      load(3, 1, "lh misalign");
      load(0, 2, "lw misalign");
      load(7, 0, "type7 as lw");
      load(4, 3, "lhu misalign");
      for (int i = 0; i < 400; i++) begin
         reset    = $urandom_range(0, 99) >= 3;
         stall    = $urandom_range(0, 99) < 25;
         flush    = $urandom_range(0, 99) < 10;
         in_valid = $urandom_range(0, 99) < 85;
         we_in    = $urandom_range(0, 99) < 80;
         rt       = 5'($urandom_range(0, 31));
         rd       = 5'($urandom_range(0, 31));
         rd_sel   = 2'($urandom_range(0, 3));
         src_sel  = 2'($urandom_range(0, 3));
         addr_lo  = 2'($urandom_range(0, 3));
         ld_type  = 3'($urandom_range(0, 7));
         for (int k = 0; k < 4; k++) src[k] = $urandom;
         step("random");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
